// File: rtl/light_phase_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// light_phase_sched : three-phase J/P/C light scheduler with pending-request skip
// and early advance; define ALLRED_EN for an S-cycle all-red gap. Revision 1.0
// ---------------------------------------------------------------------------
module light_phase_sched #(
    parameter int L  = 10,
    parameter int S  = 3,
    parameter int CW = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       N,
    input  logic [2:0] req,
    output logic       J,
    output logic       P,
    output logic       C,
    output logic       yel,
    output logic [1:0] phase,
    output logic [2:0] pend
);

    localparam logic [CW-1:0] LAST_J = CW'(L + S - 1);
    localparam logic [CW-1:0] LAST_P = CW'(L - S - 1);
    localparam logic [CW-1:0] LAST_C = CW'(L + 2 * S - 1);
    localparam logic [CW-1:0] LAST_S = CW'(S - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
`ifdef ALLRED_EN
        ,
        ALLRED = 2'd3
`endif
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] timer;
    logic [CW-1:0] timer_n;
    logic [CW-1:0] green_last;
    logic [1:0]    phase_n;
    logic [1:0]    succ1;
    logic [1:0]    succ2;
    logic [1:0]    sel;
    logic [1:0]    enter_phase;
    logic          enter_green;
    logic          passing;
    logic [2:0]    clr;
    logic [2:0]    pend_n;
    logic [3:0]    pend_ext;
`ifdef ALLRED_EN
    logic [1:0]    held;
    logic [1:0]    held_n;
`endif

    function automatic logic [1:0] rot(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Search successor, then the one after, then the current phase last.
    always_comb begin
        succ1    = rot(phase);
        succ2    = rot(succ1);
        pend_ext = {1'b0, pend};
        if (pend_ext[succ1]) begin
            sel = succ1;
        end else if (pend_ext[succ2]) begin
            sel = succ2;
        end else if (pend_ext[phase]) begin
            sel = phase;
        end else begin
            sel = succ1;
        end
    end

    always_comb begin
        case (phase)
            2'd0:    green_last = LAST_J;
            2'd1:    green_last = LAST_P;
            default: green_last = LAST_C;
        endcase
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer + CW'(1);
        phase_n     = phase;
        enter_green = 1'b0;
        enter_phase = phase;
`ifdef ALLRED_EN
        held_n      = held;
`endif
        case (state)
            IDLE: begin
                enter_green = 1'b1;
                enter_phase = 2'd0;
            end
            GREEN: begin
                if (timer == green_last || (N && timer >= LAST_S)) begin
                    state_n = YELLOW;
                    timer_n = '0;
                end
            end
            YELLOW: begin
                if (timer == LAST_S) begin
`ifdef ALLRED_EN
                    state_n = ALLRED;
                    timer_n = '0;
                    held_n  = sel;
`else
                    enter_green = 1'b1;
                    enter_phase = sel;
`endif
                end
            end
`ifdef ALLRED_EN
            ALLRED: begin
                if (timer == LAST_S) begin
                    enter_green = 1'b1;
                    enter_phase = held;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase

        if (enter_green) begin
            state_n = GREEN;
            timer_n = '0;
            phase_n = enter_phase;
        end

        // A request arriving on the clearing edge wins over the clear.
        clr = 3'b000;
        if (enter_green) begin
            clr = 3'b001 << enter_phase;
        end
        pend_n = (pend & ~clr) | req;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
            phase <= 2'd0;
            pend  <= 3'b000;
`ifdef ALLRED_EN
            held  <= 2'd0;
`endif
        end else begin
            state <= state_n;
            timer <= timer_n;
            phase <= phase_n;
            pend  <= pend_n;
`ifdef ALLRED_EN
            held  <= held_n;
`endif
        end
    end

    assign passing = (state == GREEN) || (state == YELLOW);
    assign J       = passing && (phase == 2'd0);
    assign P       = passing && (phase == 2'd1);
    assign C       = passing && (phase == 2'd2);
    assign yel     = (state == YELLOW);

endmodule
`default_nettype wire
